frame_serializer: RTL and testbench

Parametrised framed serializer, the next generation of our bit serializer. Accepts a parallel word through a valid/ready handshake and drives it onto a single idle-high line as a complete frame: start bit, data bits, optional parity bit, then stop bits, with each bit held for a programmable number of clocks. A one-entry holding register allows back-to-back frames with no idle gap. It sits between the word-producing logic and the serial output pin or link.

---
 rtl/frame_serializer.sv | 188 ++++++++++++++++++
 tb/tb_frame_serializer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/frame_serializer.sv
// rtl/frame_serializer.sv - framed serializer: start, data, optional parity, stop bits on an idle-high line
module frame_serializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  start,
  output logic                  ready,
  output logic                  busy,
  output logic                  data_out,
  output logic                  done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("frame_serializer: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("frame_serializer: STOP_BITS must be 1 or 2");
  end

  logic [2:0]            state_q, state_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic [IW-1:0]         idx_q, idx_n;
  logic [DATA_WIDTH-1:0] shift_q, shift_n, shifted;
  logic [DATA_WIDTH-1:0] hold_q, hold_n;
  logic                  par_q, par_n;
  logic                  hold_par_q, hold_par_n;
  logic                  hold_valid_q, hold_valid_n;
  logic                  accept, bit_end, last_stop, drain;
  logic                  line_n, busy_n, done_n, ready_n;

  // even parity is the XOR of the word; odd parity is its inverse
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] w);
    return (PARITY_MODE == 2) ? ~(^w) : (^w);
  endfunction

  assign accept    = start && ready;
  assign bit_end   = (cnt_q == CNT_MAX);
  assign last_stop = (state_q == S_STOP) && bit_end && (idx_q == STOP_LAST);
  assign shifted   = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);

  // next-state, counters, shifter and holding register
  always_comb begin
    state_n      = state_q;
    idx_n        = idx_q;
    shift_n      = shift_q;
    par_n        = par_q;
    hold_n       = hold_q;
    hold_par_n   = hold_par_q;
    hold_valid_n = hold_valid_q;
    drain        = 1'b0;
    cnt_n        = '0;
    if (state_q != S_IDLE) begin
      cnt_n = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        idx_n = '0;
        if (accept) begin
          state_n = S_START;
          shift_n = data_in;
          par_n   = calc_parity(data_in);
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          idx_n   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
            idx_n   = '0;
            state_n = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_n   = idx_q + 1'b1;
            shift_n = shifted;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          idx_n   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            idx_n = '0;
            if (hold_valid_q) begin
              state_n      = S_START;
              shift_n      = hold_q;
              par_n        = hold_par_q;
              hold_valid_n = 1'b0;
              drain        = 1'b1;
            end else if (accept) begin
              state_n = S_START;
              shift_n = data_in;
              par_n   = calc_parity(data_in);
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = '0;
      end
    endcase

    // a word offered mid-frame parks in the holding register
    if (accept && (state_q != S_IDLE) && !last_stop) begin
      hold_n       = data_in;
      hold_par_n   = calc_parity(data_in);
      hold_valid_n = 1'b1;
    end
  end

  // registered outputs derived from the state being entered
  always_comb begin
    case (state_n)
      S_START:  line_n = 1'b0;
      S_DATA:   line_n = (MSB_FIRST != 0) ? shift_n[DATA_WIDTH-1] : shift_n[0];
      S_PARITY: line_n = par_n;
      default:  line_n = 1'b1;
    endcase
    busy_n  = (state_n != S_IDLE);
    done_n  = (state_n == S_STOP) && (cnt_n == CNT_MAX) && (idx_n == STOP_LAST);
    // ready reopens one cycle after a drain so a new word never races the restart
    ready_n = !hold_valid_n && !drain;
  end

  // state and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      hold_q       <= '0;
      hold_par_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      data_out     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      ready        <= 1'b1;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      idx_q        <= idx_n;
      shift_q      <= shift_n;
      par_q        <= par_n;
      hold_q       <= hold_n;
      hold_par_q   <= hold_par_n;
      hold_valid_q <= hold_valid_n;
      data_out     <= line_n;
      busy         <= busy_n;
      done         <= done_n;
      ready        <= ready_n;
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// tb/tb_frame_serializer.sv - directed bench for frame_serializer over five parameter sets
module tb_frame_serializer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rstn [5];
  logic       st   [5];
  logic [7:0] din  [5];
  logic       rdy  [5];
  logic       bsy  [5];
  logic       dout [5];
  logic       dn   [5];

  int total = 0;
  int bad   = 0;

  // 0: default, 1: even parity, 2: odd parity, 3: MSB first two stops, 4: one clock per bit
  frame_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1), .MSB_FIRST(0)) u0 (
    .clock(clock), .reset(rstn[0]), .data_in(din[0]), .start(st[0]),
    .ready(rdy[0]), .busy(bsy[0]), .data_out(dout[0]), .done(dn[0]));
  frame_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1), .MSB_FIRST(0)) u1 (
    .clock(clock), .reset(rstn[1]), .data_in(din[1]), .start(st[1]),
    .ready(rdy[1]), .busy(bsy[1]), .data_out(dout[1]), .done(dn[1]));
  frame_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1), .MSB_FIRST(0)) u2 (
    .clock(clock), .reset(rstn[2]), .data_in(din[2]), .start(st[2]),
    .ready(rdy[2]), .busy(bsy[2]), .data_out(dout[2]), .done(dn[2]));
  frame_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(2), .MSB_FIRST(1)) u3 (
    .clock(clock), .reset(rstn[3]), .data_in(din[3]), .start(st[3]),
    .ready(rdy[3]), .busy(bsy[3]), .data_out(dout[3]), .done(dn[3]));
  frame_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_MODE(0), .STOP_BITS(1), .MSB_FIRST(0)) u4 (
    .clock(clock), .reset(rstn[4]), .data_in(din[4]), .start(st[4]),
    .ready(rdy[4]), .busy(bsy[4]), .data_out(dout[4]), .done(dn[4]));

  typedef struct {
    int         dut;
    int         cpb;
    logic [7:0] data;
    string      line;
    string      name;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string name, int n, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, n, act, exp);
    end
  endtask

  task automatic do_reset(int d);
    rstn[d] = 1'b0;
    st[d]   = 1'b0;
    step();
    rstn[d] = 1'b1;
  endtask

  // accept d0 at cycle 0, optionally offer acc_d at cycle acc_n and a word at ign_n,
  // then follow the expected line bit by bit; ready is expected low in [rlo, rhi)
  task automatic watch(string name, int d, int c, int f, string line, logic [7:0] d0,
                       int acc_n, logic [7:0] acc_d, int ign_n, int rlo, int rhi);
    int len;
    len = line.len() * c;
    din[d] = d0;
    st[d]  = 1'b1;
    step();
    st[d]  = 1'b0;
    din[d] = 8'h00;
    for (int n = 1; n <= len + 3; n++) begin
      logic el;
      el = (n <= len) ? (line[(n-1)/c] == "1") : 1'b1;
      chk({name, " line"},  n, dout[d], el);
      chk({name, " busy"},  n, bsy[d],  n <= len);
      chk({name, " done"},  n, dn[d],   (n <= len) && (n % (f * c) == 0));
      chk({name, " ready"}, n, rdy[d],  !(n >= rlo && n < rhi));
      st[d]  = (n == acc_n) || (n == ign_n);
      din[d] = (n == acc_n) ? acc_d : ((n == ign_n) ? 8'h55 : 8'h00);
      step();
    end
    st[d] = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, 4, 8'hA5, "0101001011",  "lsb_a5"};
    vecs[1] = '{1, 4, 8'h07, "01110000011", "even_07"};
    vecs[2] = '{2, 4, 8'h07, "01110000001", "odd_07"};
    vecs[3] = '{3, 4, 8'hA5, "01010010111", "msb_2stop_a5"};
    vecs[4] = '{4, 1, 8'hFF, "0111111111",  "cpb1_ff"};
    vecs[5] = '{1, 4, 8'h00, "00000000001", "even_00"};
    vecs[6] = '{3, 4, 8'h01, "00000000111", "msb_2stop_01"};
    vecs[7] = '{2, 4, 8'h80, "00000000101", "odd_80"};

    for (int i = 0; i < 5; i++) begin
      rstn[i] = 1'b0;
      st[i]   = 1'b0;
      din[i]  = 8'h00;
    end
    step();
    for (int i = 0; i < 5; i++) begin
      chk("reset line",  i, dout[i], 1'b1);
      chk("reset busy",  i, bsy[i],  1'b0);
      chk("reset ready", i, rdy[i],  1'b1);
      chk("reset done",  i, dn[i],   1'b0);
      rstn[i] = 1'b1;
    end
    step();

    for (int i = 0; i < 8; i++) begin
      do_reset(vecs[i].dut);
      watch(vecs[i].name, vecs[i].dut, vecs[i].cpb, vecs[i].line.len(), vecs[i].line,
            vecs[i].data, -1, 8'h00, -1, 0, 0);
    end

    // held word sent back-to-back, third start ignored while full
    do_reset(0);
    watch("b2b", 0, 4, 10, "00011110010110000111", 8'h3C, 10, 8'hC3, 20, 11, 42);

    // accept in the last stop cycle goes straight to the shifter
    do_reset(0);
    watch("straight", 0, 4, 10, "00101101010100000011", 8'h5A, 40, 8'h81, -1, 0, 0);

    // reset mid-frame with a word held
    do_reset(0);
    din[0] = 8'h3C;
    st[0]  = 1'b1;
    step();
    st[0] = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      st[0]  = (n == 5);
      din[0] = (n == 5) ? 8'hC3 : 8'h00;
      if (n == 15) begin
        chk("rst_mid held ready", n, rdy[0], 1'b0);
        chk("rst_mid busy before", n, bsy[0], 1'b1);
        rstn[0] = 1'b0;
      end
      step();
    end
    rstn[0] = 1'b1;
    for (int n = 16; n <= 70; n++) begin
      chk("rst_mid line",  n, dout[0], 1'b1);
      chk("rst_mid busy",  n, bsy[0],  1'b0);
      chk("rst_mid done",  n, dn[0],   1'b0);
      chk("rst_mid ready", n, rdy[0],  1'b1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
